// File: rtl/result_seg7_display_if.sv
// Result/display bundle between the arithmetic stage (master) and the
// seven-segment display driver (slave).
interface result_seg7_display_if #(
    parameter int unsigned BITS = 16
);
    logic [BITS-1:0] result;
    logic            busy;
    logic            done;
    logic [19:0]     bcd_out;
    logic            ovf;
    logic [3:0]      an;
    logic [6:0]      seg;
    logic            dp;

    modport master (
        output result,
        input  busy, done, bcd_out, ovf, an, seg, dp
    );

    modport slave (
        input  result,
        output busy, done, bcd_out, ovf, an, seg, dp
    );
endinterface

// File: rtl/result_seg7_display.sv
// Double-dabble binary-to-BCD converter driving a 4-digit common-anode display.
// Optional leading-zero blanking on digits 3..1 via `SEG7_LEADING_ZERO_BLANK_EN.
module result_seg7_display #(
    parameter int unsigned BITS     = 16,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    result_seg7_display_if.slave bus
);

    localparam int unsigned SH_W   = BITS + 20;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [BITS-1:0]   last_q, last_d;
    logic [SH_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [19:0]       bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [19:0]       bcd_adj;

    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [3:0]        digit;

    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 7'b1000000;
            4'd1:    seg_pattern = 7'b1111001;
            4'd2:    seg_pattern = 7'b0100100;
            4'd3:    seg_pattern = 7'b0110000;
            4'd4:    seg_pattern = 7'b0011001;
            4'd5:    seg_pattern = 7'b0010010;
            4'd6:    seg_pattern = 7'b0000010;
            4'd7:    seg_pattern = 7'b1111000;
            4'd8:    seg_pattern = 7'b0000000;
            4'd9:    seg_pattern = 7'b0010000;
            default: seg_pattern = 7'b1111111;
        endcase
    endfunction

    // Conversion FSM
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        bcd_adj = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.result != last_q) begin
                    last_d  = bus.result;
                    shreg_d = {20'b0, bus.result};
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                // add-3 on every nibble >= 5 before the shift of this edge
                bcd_adj = shreg_q[SH_W-1:BITS];
                for (int unsigned i = 0; i < 5; i++) begin
                    if (bcd_adj[i*4 +: 4] >= 4'd5)
                        bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
                end
                shreg_d = {bcd_adj, shreg_q[BITS-1:0]} << 1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == CNT_W'(BITS - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d   = shreg_q[SH_W-1:BITS];
                ovf_d   = (shreg_q[SH_W-1 -: 4] != 4'd0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Digit scan, independent of the converter
    always_comb begin
        scan_d = scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        digit = bcd_q[{idx_q, 2'b00} +: 4];
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_pattern(digit);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        case (idx_q)
            2'd1: if (bcd_q[15:4]  == 12'd0 && !ovf_q) seg_d = '1;
            2'd2: if (bcd_q[15:8]  == 8'd0  && !ovf_q) seg_d = '1;
            2'd3: if (bcd_q[15:12] == 4'd0  && !ovf_q) seg_d = '1;
            default: ;
        endcase
`else
`endif
        dp_d = ~ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            last_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;
    assign bus.an      = an_q;
    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;

endmodule

// File: tb/tb_result_seg7_display.sv
// Randomized self-checking bench for result_seg7_display (BITS=16, SCAN_DIV=4)
// against an arithmetic decimal-digit reference model.
module tb_result_seg7_display;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] seg_tab [10];
    int         p10 [5];

    result_seg7_display_if #(.BITS(16)) bus ();

    result_seg7_display #(.BITS(16), .SCAN_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r = '0;
        for (int k = 0; k < 5; k++)
            r = r | (20'((v / p10[k]) % 10) << (4 * k));
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int d);
        int dig = (v / p10[d]) % 10;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (d > 0 && v < p10[d] && v <= 9999) return 7'b1111111;
`endif
        return seg_tab[dig];
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (bus.done) break;
        end
    endtask

    task automatic convert_and_check(input int v);
        int n;
        bus.result = 16'(v);
        tick();
        check("busy_after_capture", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("latency", n, 17);
        check("bcd_out", 32'(bus.bcd_out), 32'(to_bcd(v)));
        check("ovf", 32'(bus.ovf), 32'(v > 9999));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        tick();
        check("done_one_cycle", 32'(bus.done), 32'd0);
    endtask

    task automatic disp_check(input int v);
        int prev_idx = -1;
        int run = 0;
        bit started = 0;
        for (int s = 0; s < 16; s++) begin
            int idx = -1;
            tick();
            for (int i = 0; i < 4; i++)
                if (bus.an == ~(4'b0001 << i)) idx = i;
            check("an_onehot", 32'(idx >= 0), 32'd1);
            if (idx >= 0) begin
                check("seg", 32'(bus.seg), 32'(exp_seg(v, idx)));
                check("dp", 32'(bus.dp), 32'(v <= 9999));
            end
            if (prev_idx >= 0 && idx != prev_idx) begin
                check("an_step", idx, (prev_idx + 1) % 4);
                if (started) check("scan_dwell", run, 4);
                started = 1;
                run = 1;
            end else begin
                run++;
            end
            prev_idx = idx;
        end
    endtask

    initial begin
        int nd;
        int dt [4];
        logic [19:0] db [4];
        int last_v;
        int v;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        p10 = '{1, 10, 100, 1000, 10000};

        // reset
        bus.result = '0;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_an", 32'(bus.an), 32'hf);
        check("rst_seg", 32'(bus.seg), 32'h7f);
        check("rst_dp", 32'(bus.dp), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd_out), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b1;
        tick();
        check("rel_an", 32'(bus.an), 32'he);
        check("rel_seg", 32'(bus.seg), 32'h40);
        check("zero_no_conv", 32'(bus.busy), 32'd0);

        // 1234
        convert_and_check(1234);
        disp_check(1234);

        // unchanged value must not reconvert
        repeat (3) begin
            tick();
            check("same_no_busy", 32'(bus.busy), 32'd0);
            check("same_no_done", 32'(bus.done), 32'd0);
        end

        // overflow
        convert_and_check(65535);
        disp_check(65535);

        // change while busy
        nd = 0;
        dt = '{0, 0, 0, 0};
        db = '{20'd0, 20'd0, 20'd0, 20'd0};
        bus.result = 16'd100;
        tick();
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (bus.done) begin
                if (nd < 4) begin
                    dt[nd] = t;
                    db[nd] = bus.bcd_out;
                end
                nd++;
            end
            if (t == 5) bus.result = 16'd200;
        end
        check("two_done_pulses", nd, 2);
        check("first_done_time", dt[0], 17);
        check("first_bcd", 32'(db[0]), 32'h00100);
        check("second_done_gap", dt[1] - dt[0], 18);
        check("second_bcd", 32'(db[1]), 32'h00200);

        // reset mid-conversion
        nd = 0;
        bus.result = 16'd999;
        tick();
        repeat (8) begin
            tick();
            if (bus.done) nd++;
        end
        rst = 1'b0;
        tick();
        if (bus.done) nd++;
        check("abort_no_done", nd, 0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bcd", 32'(bus.bcd_out), 32'd0);
        check("abort_an", 32'(bus.an), 32'hf);
        rst = 1'b1;
        convert_and_check(999);
        disp_check(999);

        // small value: leading-zero handling
        convert_and_check(7);
        disp_check(7);
        last_v = 7;

        // random values
        for (int r = 0; r < 12; r++) begin
            v = int'($urandom_range(0, 65535));
            if (v == last_v) v = (v + 1) % 65536;
            convert_and_check(v);
            disp_check(v);
            last_v = v;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
